// File: rtl/conc_stim_player_if.sv
// -----------------------------------------------------------------------------
// conc_stim_player_if
//   Bundles the table-load and replay signals of conc_stim_player.
//
//   Handshake: a table write happens on a rising clock edge where ld_valid
//   and ld_ready are both 1. ld_valid may be raised without waiting for
//   ld_ready. A write offered while ld_ready is 0 is dropped, not held.
//   The replay side has no back-pressure. When step_valid is 1, obs, stbi,
//   x_in and pc describe one table entry for exactly that cycle.
//
//   Signals (master = harness/driver, slave = player):
//     ld_clear   m->s  empty the table (write pointer and length to 0)
//     ld_valid   m->s  opcode write request
//     ld_data    m->s  opcode to append
//     ld_ready   s->m  table accepts a write this cycle
//     start      m->s  begin replay from entry 0
//     stop       m->s  abort replay
//     obs        s->m  opcode bit 7 of the presented step
//     stbi       s->m  opcode bit 6 of the presented step
//     x_in       s->m  opcode bits 5:0 of the presented step
//     step_valid s->m  obs/stbi/x_in carry a table entry this cycle
//     pc         s->m  index of the presented entry
//     busy       s->m  replay in progress
//     done       s->m  replay finished or aborted
// -----------------------------------------------------------------------------
interface conc_stim_player_if #(
  parameter int AW = 8
);
  logic          ld_clear;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic          start;
  logic          stop;
  logic          obs;
  logic          stbi;
  logic [5:0]    x_in;
  logic          step_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  modport master (
    output ld_clear, ld_valid, ld_data, start, stop,
    input  ld_ready, obs, stbi, x_in, step_valid, pc, busy, done
  );

  modport slave (
    input  ld_clear, ld_valid, ld_data, start, stop,
    output ld_ready, obs, stbi, x_in, step_valid, pc, busy, done
  );
endinterface

// File: rtl/conc_stim_player.sv
// -----------------------------------------------------------------------------
// conc_stim_player
//   Opcode stream player. It holds a loadable table of 8-bit opcodes and
//   replays them one per clock. Each opcode is split into the observation
//   flag (bit 7), the strobe (bit 6) and the 6-bit data input (bits 5:0) of
//   the downstream device. The player exports the step index (pc) so that
//   traces can be correlated.
//
//   Parameters:
//     DEPTH  number of opcode entries (1..256)
//     AW     address/length width; 2**AW must be greater than DEPTH
//
//   Ports:
//     clock        rising-edge clock
//     reset        synchronous active-high reset
//     bus          conc_stim_player_if.slave (load + replay signals)
//     dbg_state_o  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
//   Optional build macro:
//     CONC_LOOP_EN  When defined, replay wraps from the last entry back to
//                   entry 0 with no bubble. It leaves RUN only on stop or on
//                   reset.
//
//   Timing: a start sampled at edge E0 gives busy after E0. Entry k is on
//   the outputs after E(k+1). In single-pass mode, done rises after
//   E(length+1). The table read is synchronous, and the read register is
//   the output register.
// -----------------------------------------------------------------------------
module conc_stim_player #(
  parameter int DEPTH = 101,
  parameter int AW    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  conc_stim_player_if.slave    bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index width actually needed by the table array.
  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LEN_MAX = AW'(DEPTH);
  localparam logic [AW-1:0] ONE     = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;      // write pointer
  logic [AW-1:0] len_q, len_d;    // number of valid entries
  logic [AW-1:0] rd_q, rd_d;      // index to present on the next RUN edge
  logic [7:0]    op_q, op_d;      // presented opcode (zero when idle)
  logic          vld_q, vld_d;
  logic [AW-1:0] pc_q, pc_d;

  logic [7:0]    mem_q [DEPTH];
  logic          mem_we;

  logic          busy_o, done_o, ld_ready_o;
  logic          run_end;         // RUN has nothing left to present
  logic [AW-1:0] rd_next;         // read index after the current one

  // ---------------------------------------------------------------------------
  // Replay sequencing: single pass or wrap-around
  // ---------------------------------------------------------------------------
`ifdef CONC_LOOP_EN
  // RUN is entered only with len_q >= 1, so len_q - 1 cannot underflow there.
  assign run_end = 1'b0;
  assign rd_next = (rd_q == len_q - ONE) ? '0 : rd_q + ONE;
`else
  assign run_end = (rd_q == len_q);
  assign rd_next = rd_q + ONE;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. In IDLE/DONE the priority is clear, then start.
  // start beats a simultaneous stop because stop only matters in RUN.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.ld_clear)   state_d = ST_IDLE;
        else if (bus.start) state_d = (len_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (bus.stop || run_end) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o     = (state_q == ST_RUN);
    done_o     = (state_q == ST_DONE);
    ld_ready_o = (len_q < LEN_MAX) && (state_q != ST_RUN);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: table bookkeeping and the presented step
  // ---------------------------------------------------------------------------
  always_comb begin
    wp_d   = wp_q;
    len_d  = len_q;
    rd_d   = rd_q;
    op_d   = op_q;
    vld_d  = vld_q;
    pc_d   = pc_q;
    mem_we = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.ld_clear) begin
          // Only the bookkeeping is cleared. The stored opcodes stay in place.
          wp_d  = '0;
          len_d = '0;
        end else if (bus.start) begin
          // Any write offered on the same edge is dropped.
          rd_d  = '0;
          pc_d  = '0;
          op_d  = '0;
          vld_d = 1'b0;
        end else if (bus.ld_valid && ld_ready_o) begin
          mem_we = 1'b1;
          wp_d   = wp_q + ONE;
          len_d  = len_q + ONE;
        end
      end
      ST_RUN: begin
        if (bus.stop || run_end) begin
          // pc keeps the last presented index.
          op_d  = '0;
          vld_d = 1'b0;
        end else begin
          op_d  = mem_q[rd_q[IW-1:0]];
          vld_d = 1'b1;
          pc_d  = rd_q;
          rd_d  = rd_next;
        end
      end
      default: begin
        op_d  = '0;
        vld_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q  <= '0;
      len_q <= '0;
      rd_q  <= '0;
      op_q  <= '0;
      vld_q <= 1'b0;
      pc_q  <= '0;
    end else begin
      wp_q  <= wp_d;
      len_q <= len_d;
      rd_q  <= rd_d;
      op_q  <= op_d;
      vld_q <= vld_d;
      pc_q  <= pc_d;
    end
  end

  // Table storage is not reset. A reset only forgets the length.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[wp_q[IW-1:0]] <= bus.ld_data;
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign bus.obs        = op_q[7];
  assign bus.stbi       = op_q[6];
  assign bus.x_in       = op_q[5:0];
  assign bus.step_valid = vld_q;
  assign bus.pc         = pc_q;
  assign bus.busy       = busy_o;
  assign bus.done       = done_o;
  assign bus.ld_ready   = ld_ready_o;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_conc_stim_player.sv
// -----------------------------------------------------------------------------
// tb_conc_stim_player
//   Self-checking bench for conc_stim_player. The model keeps the loaded
//   table as a byte queue. Before each replay it derives the expected
//   (pc, opcode) stream into exp_q, and the bench compares every presented
//   step against that stream. Build with CONC_LOOP_EN to check wrap-around.
// -----------------------------------------------------------------------------
module tb_conc_stim_player;
  localparam int DEPTH = 101;
  localparam int AW    = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  conc_stim_player_if #(.AW(AW)) bus();
  logic [1:0] dbg_state;

  conc_stim_player #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- model / scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [7:0]      tbl_q[$];   // bytes currently counted in the table
  logic [AW+7:0]   exp_q[$];   // expected {pc, opcode} per presented step

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed,
                     input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic chk_quiet_outputs(input string tag);
    chk({tag, "_vld"}, 32'(bus.step_valid), 0);
    chk({tag, "_op"},  32'({bus.obs, bus.stbi, bus.x_in}), 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tbl_q.delete();
    chk_quiet_outputs("rst");
    chk("rst_pc",    32'(bus.pc), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_done",  32'(bus.done), 0);
    chk("rst_ready", 32'(bus.ld_ready), 1);
  endtask

  task automatic load_byte(input logic [7:0] b);
    bit acc;
    acc = (tbl_q.size() < DEPTH);
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    chk("ld_ready", 32'(bus.ld_ready), 32'(acc));
    tick();
    bus.ld_valid = 1'b0;
    if (acc) tbl_q.push_back(b);
  endtask

  task automatic clear_tbl();
    bus.ld_clear = 1'b1;
    tick();
    bus.ld_clear = 1'b0;
    tbl_q.delete();
    chk("clr_busy",  32'(bus.busy), 0);
    chk("clr_done",  32'(bus.done), 0);
    chk("clr_ready", 32'(bus.ld_ready), 1);
  endtask

  // stop_at: step number after which stop is raised (-1 means none).
  // noise: toggle start/ld_valid/ld_clear during RUN; these must be ignored.
  // start_noise: also raise ld_valid and stop on the start edge; start must win.
  task automatic run_replay(input int stop_at, input bit noise, input bit start_noise);
    int len;
    int steps;
    int sa;
    logic [AW+7:0] e;
    len = tbl_q.size();
    sa  = stop_at;
`ifdef CONC_LOOP_EN
    if (sa < 0) sa = 2 * len;
    steps = (len == 0) ? 0 : sa + 1;
`else
    steps = (len == 0) ? 0 : ((sa < 0 || sa >= len) ? len : sa + 1);
`endif
    exp_q.delete();
    for (int i = 0; i < steps; i++)
      exp_q.push_back({AW'(i % len), tbl_q[i % len]});

    bus.start = 1'b1;
    if (start_noise) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'($urandom);
      bus.stop     = 1'b1;
    end
    tick();
    bus.start = 1'b0; bus.ld_valid = 1'b0; bus.stop = 1'b0;
    chk("start_busy", 32'(bus.busy), 32'(len != 0));
    chk("start_done", 32'(bus.done), 32'(len == 0));
    chk("start_vld",  32'(bus.step_valid), 0);

    for (int i = 0; i < steps; i++) begin
      if (noise) begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.ld_valid = 1'($urandom_range(0, 1));
        bus.ld_clear = 1'($urandom_range(0, 1));
        bus.ld_data  = 8'($urandom);
      end
      tick();
      bus.start = 1'b0; bus.ld_valid = 1'b0; bus.ld_clear = 1'b0;
      e = exp_q.pop_front();
      chk("step_vld",   32'(bus.step_valid), 1);
      chk("step_pc",    32'(bus.pc), 32'(e[AW+7:8]));
      chk("step_op",    32'({bus.obs, bus.stbi, bus.x_in}), 32'(e[7:0]));
      chk("step_busy",  32'(bus.busy), 1);
      chk("step_ready", 32'(bus.ld_ready), 0);
      if (i == sa) bus.stop = 1'b1;
    end
    if (len != 0) begin
      tick();
      bus.stop = 1'b0;
    end
    chk_quiet_outputs("end");
    chk("end_busy",  32'(bus.busy), 0);
    chk("end_done",  32'(bus.done), 1);
    chk("end_pc",    32'(bus.pc), (len == 0) ? 0 : 32'((steps - 1) % len));
    chk("end_ready", 32'(bus.ld_ready), 32'(len < DEPTH));
    chk("end_left",  32'(exp_q.size()), 0);
    tick();
    chk("hold_done", 32'(bus.done), 1);
    chk("hold_vld",  32'(bus.step_valid), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    bus.ld_clear = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = 8'h00;
    bus.start = 1'b0; bus.stop = 1'b0;
    tick();

    // Reset state, then the three-opcode example.
    do_reset();
    load_byte(8'hC5); load_byte(8'h3F); load_byte(8'h80);
    run_replay(-1, 1'b0, 1'b0);

    // Empty table: immediate done.
    clear_tbl();
    run_replay(-1, 1'b0, 1'b0);

    // Fill to DEPTH; the next write is dropped.
    clear_tbl();
    for (int i = 0; i < DEPTH + 1; i++) load_byte(8'($urandom));
    chk("full_ready", 32'(bus.ld_ready), 0);
    chk("full_len", 32'(tbl_q.size()), DEPTH);
    run_replay(-1, 1'b0, 1'b0);

    // Abort while pc=2.
    clear_tbl();
    for (int i = 0; i < 5; i++) load_byte(8'($urandom));
    run_replay(2, 1'b0, 1'b0);

    // Reset mid-run at pc=3, then start without reloading.
    clear_tbl();
    for (int i = 0; i < 5; i++) load_byte(8'($urandom));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_pc", 32'(bus.pc), 32'(i));
      chk("mr_op", 32'({bus.obs, bus.stbi, bus.x_in}), 32'(tbl_q[i]));
    end
    do_reset();
    run_replay(-1, 1'b0, 1'b0);

    // Clear and start on the same edge: clear wins, and the player returns to IDLE.
    load_byte(8'h11);
    bus.ld_clear = 1'b1; bus.start = 1'b1;
    tick();
    bus.ld_clear = 1'b0; bus.start = 1'b0;
    tbl_q.delete();
    chk("clrst_busy", 32'(bus.busy), 0);
    chk("clrst_done", 32'(bus.done), 0);

    // Start with a write and a stop on the same edge; start wins and the write is dropped.
    load_byte(8'h5A); load_byte(8'hA5);
    run_replay(-1, 1'b0, 1'b1);

`ifdef CONC_LOOP_EN
    // Two entries wrap without a bubble: pc 0,1,0,1,0,1, then stop.
    clear_tbl();
    load_byte(8'h81); load_byte(8'h42);
    run_replay(5, 1'b0, 1'b0);
`endif

    // Random tables, random stops, random ignored inputs during RUN.
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) == 1) clear_tbl();
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) load_byte(8'($urandom));
      run_replay($urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 12)),
                 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conc_stim_player.md
# conc_stim_player

Synthesizable opcode stream player that sits directly upstream of the device under test in the concolic replay harness. It holds a loadable table of 8-bit opcodes and replays them one per clock, splitting each opcode into the observation flag, the strobe input and the 6-bit data input of the DUT. It replaces a behavioural memory read with a cycle-exact, resettable, abortable sequencer that also exports the step index for trace correlation.

## Interface
- DEPTH, 101, number of opcode entries (1..256)
- AW, 8, address/length width; must satisfy 2^AW > DEPTH
- clock  in  1  rising-edge clock, sole clock domain
- reset  in  1  synchronous, active-high reset
- ld_clear  in  1  empties the table (write pointer and length to 0)
- ld_valid  in  1  opcode write request
- ld_data  in  8  opcode to append at write pointer
- ld_ready  out  1  table accepts a write this cycle
- start  in  1  begin replay from entry 0
- stop  in  1  abort replay
- obs  out  1  opcode bit 7 of presented step
- stbi  out  1  opcode bit 6 of presented step
- x_in  out  6  opcode bits 5:0 of presented step
- step_valid  out  1  obs/stbi/x_in carry a table entry this cycle
- pc  out  AW  index of presented entry
- busy  out  1  state is RUN
- done  out  1  state is DONE

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE; length=0, write pointer=0; all outputs 0 except ld_ready=1.
- Load (IDLE or DONE only): ld_ready = (length < DEPTH) and not RUN. On ld_valid & ld_ready: mem[wp] <= ld_data, wp and length +1. Writes with ld_ready=0 are dropped.
- ld_clear in IDLE/DONE: length=0, wp=0, state -> IDLE; table contents not erased. Ignored in RUN.
- Priority in IDLE/DONE, same edge: ld_clear > start > ld_valid. start with ld_valid: write dropped.
- start in IDLE/DONE: length=0 -> DONE immediately, no steps; otherwise -> RUN, read address 0.
- RUN: entry k presented for exactly one cycle; entries 0..length-1 presented in order, no gaps.
- Opcode split fixed: obs=op[7], stbi=op[6], x_in=op[5:0].
- After last entry: outputs and step_valid to 0, state -> DONE.
- stop in RUN: next edge outputs 0, step_valid=0, -> DONE; entry presented that cycle counts as applied. stop outside RUN ignored. stop and start together in IDLE/DONE: start wins.
- start in RUN ignored (no restart).
- pc holds last presented index after DONE; reset to 0 on start and reset.
- Reset mid-run: next edge IDLE, outputs 0, length=0 (table must be reloaded).

## Timing
- Memory read synchronous, one cycle; all outputs registered.
- start sampled at edge E0 -> busy=1 after E0; entry 0 on outputs after E1 with step_valid=1, pc=0; entry k after E(k+1).
- After E(length+1): step_valid=0, busy=0, done=1.
- Total replay latency start-to-done: length+1 edges.
- stop sampled at edge Es -> outputs 0 after Es.
- Load throughput one opcode per cycle; ld_ready combinational from state and length.

## Configuration
- CONC_LOOP_EN defined: after entry length-1, RUN continues with entry 0 on the next cycle (pc wraps to 0, no bubble); exits only via stop or reset; done never set by running off the end.
- Undefined: single pass, behaviour as above.

## Test plan
- Reset, load 8'hC5, 8'h3F, 8'h80, start -> three consecutive step_valid cycles: (obs,stbi,x_in)=(1,1,5),(0,0,63),(1,0,0), pc 0,1,2; done=1 on next cycle.
- Load DEPTH entries -> ld_ready=0 after 101st write; 102nd write dropped; replay shows exactly 101 steps.
- Start with empty table -> done=1 after one edge, step_valid never asserted.
- Load 5 entries, start, stop asserted while pc=2 -> pc 2 is last step, outputs 0 next cycle, done=1, pc stays 2.
- Reset asserted mid-run at pc=3 -> outputs 0, IDLE next edge; start without reload -> immediate done.
- CONC_LOOP_EN: load 2 entries, start, run 6 cycles -> pc 0,1,0,1,0,1 contiguous; stop -> done.
